// File: rtl/signed_mac_accumulator.sv
// Purpose: burst multiply-accumulate of signed 8x8 operand pairs into a saturating ACC_W-bit sum.
// Latency: out_valid rises 3 edges after the final pair transfers; one accumulation per cycle.
// Backpressure: in_ready only in RUN; result held in DONE until out_ready, start ignored unless IDLE.

// Combinational 8x8 two's-complement multiplier feeding the accumulator.
module main (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] p
);
    logic [15:0] x_ext;
    logic [15:0] y_ext;

    // Sign-extend both operands so the low 16 bits of the product are the signed result.
    always_comb begin
        x_ext = {{8{x[7]}}, x};
        y_ext = {{8{y[7]}}, y};
        p     = x_ext * y_ext;
    end
endmodule

module signed_mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       x,
    input  logic [7:0]       y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             sat,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [7:0]       x_q, x_d;
    logic [7:0]       y_q, y_d;
    logic             v1_q, v1_d;
    logic [15:0]      p_q, p_d;
    logic             v2_q, v2_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;

    logic             xfer;
    logic             clr;
    logic [15:0]      prod;
    logic [ACC_W:0]   sum_w;

    main u_mul (
        .x (x_q),
        .y (y_q),
        .p (prod)
    );

    // FSM next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        clr       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    count_d = '0;
                    clr     = 1'b1;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                xfer     = in_valid;
                if (in_valid) begin
                    count_d = count_q + 1'b1;
                    if (count_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Wait until the last product has reached the accumulator.
                if (!v1_q && !v2_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand and product pipeline stages.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        p_d  = p_q;
        v1_d = xfer;
        v2_d = v1_q;
        if (xfer) begin
            x_d = x;
            y_d = y;
        end
        if (v1_q) begin
            p_d = prod;
        end
    end

    // Saturating accumulate: overflow shows as disagreement between the top two sum bits.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        sum_w = {{(ACC_W - 15){p_q[15]}}, p_q} + {acc_q[ACC_W-1], acc_q};
        if (clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (v2_q) begin
            if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
                sat_d = 1'b1;
                acc_d = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                acc_d = sum_w[ACC_W-1:0];
            end
        end
    end

    // State, pipeline and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            v1_q    <= 1'b0;
            p_q     <= '0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            x_q     <= x_d;
            y_q     <= y_d;
            v1_q    <= v1_d;
            p_q     <= p_d;
            v2_q    <= v2_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    assign acc_out = acc_q;
    assign sat     = sat_q;
endmodule

// File: tb/tb_signed_mac_accumulator.sv
// Bench for signed_mac_accumulator: one 24-bit and one 16-bit accumulator driven in lockstep.
// Expected sums come from a saturating model, queued per burst and popped at out_valid.
module tb_signed_mac_accumulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        out_ready;

    logic        in_ready24, out_valid24, sat24, busy24;
    logic [23:0] acc24;
    logic        in_ready16, out_valid16, sat16, busy16;
    logic [15:0] acc16;

    always #5 clk = ~clk;

    signed_mac_accumulator #(.ACC_W(24), .LEN_W(8)) dut24 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready24), .x(x), .y(y),
        .out_valid(out_valid24), .out_ready(out_ready),
        .acc_out(acc24), .sat(sat24), .busy(busy24)
    );

    signed_mac_accumulator #(.ACC_W(16), .LEN_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready16), .x(x), .y(y),
        .out_valid(out_valid16), .out_ready(out_ready),
        .acc_out(acc16), .sat(sat16), .busy(busy16)
    );

    typedef struct {
        int a24;
        int a16;
        int s24;
        int s16;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   m24, m16, ms24, ms16;
    int   cyc;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_add(input int p);
        longint t;
        t = longint'(m24) + longint'(p);
        if (t > 64'sd8388607) begin m24 = 8388607; ms24 = 1; end
        else if (t < -64'sd8388608) begin m24 = -8388608; ms24 = 1; end
        else m24 = int'(t);
        t = longint'(m16) + longint'(p);
        if (t > 64'sd32767) begin m16 = 32767; ms16 = 1; end
        else if (t < -64'sd32768) begin m16 = -32768; ms16 = 1; end
        else m16 = int'(t);
    endtask

    task automatic push_exp();
        exp_t e;
        e.a24 = m24; e.a16 = m16; e.s24 = ms24; e.s16 = ms16;
        sbq.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic start_burst(input int l);
        start = 1'b1;
        len   = 8'(l);
        cycle();
        start = 1'b0;
        m24 = 0; m16 = 0; ms24 = 0; ms16 = 0;
        if (l == 0) push_exp();
    endtask

    // in_ready only changes on edges, so seeing it high now means the next edge transfers.
    task automatic send(input int xv, input int yv);
        int done;
        done = 0;
        in_valid = 1'b1;
        x = 8'(xv);
        y = 8'(yv);
        for (int n = 0; n < 50 && done == 0; n++) begin
            if (in_ready24) done = 1;
            cycle();
        end
        in_valid = 1'b0;
        chk("xfer_seen", done, 1);
        if (done != 0) model_add(xv * yv);
    endtask

    task automatic wait_result(input string tag, output int n);
        exp_t e;
        n = 0;
        while (!out_valid24 && n < 60) begin
            cycle();
            n++;
        end
        chk({tag, "_ovld24"}, int'(out_valid24), 1);
        chk({tag, "_ovld16"}, int'(out_valid16), 1);
        chk({tag, "_queued"}, sbq.size(), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_acc24"}, int'($signed(acc24)), e.a24);
            chk({tag, "_sat24"}, int'(sat24), e.s24);
            chk({tag, "_acc16"}, int'($signed(acc16)), e.a16);
            chk({tag, "_sat16"}, int'(sat16), e.s16);
        end
    endtask

    task automatic accept_result(input string tag);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk({tag, "_busy_after"}, int'(busy24), 0);
        chk({tag, "_busy16_after"}, int'(busy16), 0);
        chk({tag, "_ovld_after"}, int'(out_valid24), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        x = '0; y = '0; out_ready = 1'b0;
        m24 = 0; m16 = 0; ms24 = 0; ms16 = 0;

        // Reset state
        #12;
        chk("rst_in_ready", int'(in_ready24), 0);
        chk("rst_out_valid", int'(out_valid24), 0);
        chk("rst_busy", int'(busy24), 0);
        chk("rst_sat", int'(sat24), 0);
        chk("rst_acc", int'($signed(acc24)), 0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Back-to-back burst of three, product of -128*-128 included
        start_burst(3);
        chk("t1_busy", int'(busy24), 1);
        send(3, 4);
        send(-2, 5);
        send(-128, -128);
        push_exp();
        chk("t1_in_ready_drain", int'(in_ready24), 0);
        wait_result("t1", cyc);
        chk("t1_latency", cyc, 3);
        accept_result("t1");

        // Zero-length burst goes straight to DONE
        start_burst(0);
        chk("t2_in_ready", int'(in_ready24), 0);
        wait_result("t2", cyc);
        chk("t2_latency", cyc, 0);
        accept_result("t2");

        // Gapped valid pattern; a fifth pair must be ignored
        start_burst(4);
        send(1, 1);
        idle(2);
        send(2, 2);
        send(-3, 3);
        idle(1);
        send(127, 127);
        push_exp();
        chk("t3_in_ready_drop", int'(in_ready24), 0);
        in_valid = 1'b1;
        x = 8'd50;
        y = 8'd50;
        wait_result("t3", cyc);
        chk("t3_latency", cyc, 3);
        chk("t3_in_ready_done", int'(in_ready24), 0);
        in_valid = 1'b0;
        accept_result("t3");

        // Positive saturation at 16 bits, none at 24
        start_burst(2);
        send(-128, -128);
        send(-128, -128);
        push_exp();
        wait_result("t4", cyc);
        accept_result("t4");

        // Negative saturation; sat cleared by the new start first
        start_burst(3);
        chk("t5_sat16_cleared", int'(sat16), 0);
        send(-128, 127);
        send(-128, 127);
        send(-128, 127);
        push_exp();
        wait_result("t5", cyc);

        // Result held in DONE under backpressure, start ignored
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            len = 8'd2;
            cycle();
            chk("t6_hold_ovld", int'(out_valid16), 1);
            chk("t6_hold_acc16", int'($signed(acc16)), m16);
            chk("t6_hold_acc24", int'($signed(acc24)), m24);
        end
        start = 1'b0;
        accept_result("t6");

        // Asynchronous reset mid-burst
        start_burst(5);
        send(7, 7);
        send(3, 3);
        idle(3);
        chk("t7_acc_pre_rst", int'($signed(acc24)), m24);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_in_ready", int'(in_ready24), 0);
        chk("t7_rst_busy", int'(busy24), 0);
        chk("t7_rst_out_valid", int'(out_valid24), 0);
        chk("t7_rst_acc24", int'($signed(acc24)), 0);
        chk("t7_rst_acc16", int'($signed(acc16)), 0);
        chk("t7_rst_sat", int'(sat16), 0);
        cycle();
        rst_n = 1'b1;
        cycle();
        start_burst(1);
        send(5, -6);
        push_exp();
        wait_result("t7", cyc);
        accept_result("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
